frame_kernel_scheduler: RTL and testbench

- Frame-level controller in front of the convolution filter and zebra crossing detector in the camera pattern-recognition path.
- Admits whole frames only, selects the edge kernel per frame (alternating vertical and horizontal Sobel), and waits for the detector's per-frame verdict.
- Produces a debounced crossing decision by N-of-M voting over recent frames.

---
 rtl/frame_kernel_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_frame_kernel_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_kernel_scheduler.sv
// frame_kernel_scheduler
// Frame-level gate in front of the convolution filter and zebra-crossing
// detector. Admits whole frames only, alternates the Sobel kernel per frame,
// collects the detector verdict and debounces it with an N-of-M vote.
//
// Optional feature macro: FRAME_KERNEL_SCHEDULER_CFG_WR_EN
//   Defined   : cfg_we/cfg_sel/cfg_idx/cfg_data ports; both kernels live in a
//               writable 2x9 coefficient bank. Writes aimed at the bank that is
//               currently driving the filter are parked in a one-entry pending
//               register and applied at the frame boundary.
//   Undefined : kernels are the fixed vertical/horizontal Sobel constants.
//
// state  | meaning
// IDLE   | waiting for sof; camera pixels are accepted and dropped
// STREAM | gating exactly one frame of pixels to the filter
// DRAIN  | frame delivered, camera stalled, waiting for detector verdict
// VOTE   | record verdict, update vote, swap kernel, back to IDLE
module frame_kernel_scheduler #(
    parameter int IMG_WIDTH     = 320,
    parameter int IMG_HEIGHT    = 240,
    parameter int W             = 8,
    parameter int HIST_LEN      = 8,
    parameter int VOTE_THRESH   = 5,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
`ifdef FRAME_KERNEL_SCHEDULER_CFG_WR_EN
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [3:0]       cfg_idx,
    input  logic [W-1:0]     cfg_data,
`endif
    input  logic             sof,
    input  logic             x_valid_in,
    output logic             x_ready_in,
    output logic             x_valid_out,
    input  logic             x_ready_out,
    output logic [9*W-1:0]   kernel_flat,
    output logic             kernel_sel,
    input  logic             det_valid,
    input  logic             det_crossing,
    input  logic [7:0]       det_stripes,
    output logic             crossing_confirmed,
    output logic [7:0]       last_stripes,
    output logic             frame_done,
    output logic             timeout_flag
);

    localparam int PIX_TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int PCW       = $clog2(PIX_TOTAL + 1);
    localparam int DCW       = $clog2(DRAIN_TIMEOUT + 1);
    localparam int PW        = $clog2(HIST_LEN + 1);

    // Element [r][c] sits at index r*3+c.
    localparam int SOBEL_V [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    localparam int SOBEL_H [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, VOTE} state_t;

    state_t              state;
    logic [PCW-1:0]      pix_cnt;
    logic [DCW-1:0]      drain_cnt;
    logic                verdict;
    logic [HIST_LEN-1:0] hist;
    logic [HIST_LEN-1:0] hist_next;
    logic [PW-1:0]       pop;
    logic                vote_next;
    logic                stream_open;
    logic                xfer;
    logic                last_pix;

    // A sof in IDLE opens the gate in the same cycle so a coincident first
    // pixel is admitted; reset forces both handshake outputs low.
    assign stream_open = (state == STREAM) || ((state == IDLE) && sof);
    assign x_valid_out = !rst && x_valid_in && stream_open;
    assign x_ready_in  = !rst && (stream_open ? x_ready_out : (state == IDLE));
    assign xfer        = x_valid_out && x_ready_out;
    assign last_pix    = xfer && (pix_cnt == PCW'(PIX_TOTAL - 1));

    // Next history and its vote, consumed only in VOTE.
    always_comb begin
        hist_next = (hist << 1) | HIST_LEN'(verdict);
        pop       = '0;
        for (int i = 0; i < HIST_LEN; i++) begin
            pop = pop + PW'(hist_next[i]);
        end
        vote_next = (int'(pop) >= VOTE_THRESH);
    end

    // Frame sequencing FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            pix_cnt            <= '0;
            drain_cnt          <= '0;
            verdict            <= 1'b0;
            hist               <= '0;
            crossing_confirmed <= 1'b0;
            last_stripes       <= '0;
            frame_done         <= 1'b0;
            timeout_flag       <= 1'b0;
            kernel_sel         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sof) begin
                        pix_cnt <= xfer ? PCW'(1) : '0;
                        if (last_pix) begin
                            drain_cnt <= DCW'(DRAIN_TIMEOUT);
                            state     <= DRAIN;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        pix_cnt <= pix_cnt + PCW'(1);
                        if (last_pix) begin
                            drain_cnt <= DCW'(DRAIN_TIMEOUT);
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (det_valid) begin
                        verdict      <= det_crossing;
                        last_stripes <= det_stripes;
                        state        <= VOTE;
                    end else if (drain_cnt == '0) begin
                        verdict      <= 1'b0;
                        timeout_flag <= 1'b1;
                        state        <= VOTE;
                    end else begin
                        drain_cnt <= drain_cnt - DCW'(1);
                    end
                end
                VOTE: begin
                    hist               <= hist_next;
                    crossing_confirmed <= vote_next;
                    frame_done         <= 1'b1;
                    kernel_sel         <= ~kernel_sel;
                    pix_cnt            <= '0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FRAME_KERNEL_SCHEDULER_CFG_WR_EN
    logic [W-1:0] coef [2][9];
    logic         pend_valid;
    logic [3:0]   pend_idx;
    logic [W-1:0] pend_data;
    logic         cfg_ok;

    assign cfg_ok = cfg_we && (cfg_idx <= 4'd8);

    // Coefficient bank; the live bank only changes at the frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                coef[0][i] <= W'(SOBEL_V[i]);
                coef[1][i] <= W'(SOBEL_H[i]);
            end
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            pend_data  <= '0;
        end else if (state == VOTE) begin
            if (pend_valid) begin
                coef[kernel_sel][pend_idx] <= pend_data;
            end
            pend_valid <= 1'b0;
            if (cfg_ok) begin
                coef[cfg_sel][cfg_idx] <= cfg_data;
            end
        end else if (cfg_ok) begin
            if (cfg_sel == kernel_sel) begin
                pend_valid <= 1'b1;
                pend_idx   <= cfg_idx;
                pend_data  <= cfg_data;
            end else begin
                coef[cfg_sel][cfg_idx] <= cfg_data;
            end
        end
    end

    // Present the active bank.
    always_comb begin
        kernel_flat = '0;
        for (int i = 0; i < 9; i++) begin
            kernel_flat[i*W +: W] = coef[kernel_sel][i];
        end
    end
`else
    // Present the fixed Sobel kernel for the current frame.
    always_comb begin
        kernel_flat = '0;
        for (int i = 0; i < 9; i++) begin
            kernel_flat[i*W +: W] = kernel_sel ? W'(SOBEL_H[i]) : W'(SOBEL_V[i]);
        end
    end
`endif

endmodule

// File: tb/tb_frame_kernel_scheduler.sv
// Directed bench for frame_kernel_scheduler on a reduced 4x3 frame with a
// 20-cycle drain timeout.
module tb_frame_kernel_scheduler;

    localparam int IW  = 4;
    localparam int IH  = 3;
    localparam int PIX = IW * IH;
    localparam int WD  = 8;
    localparam int T   = 20;

    localparam logic [9*WD-1:0] KV = {8'h01, 8'h00, 8'hFF, 8'h02, 8'h00, 8'hFE, 8'h01, 8'h00, 8'hFF};
    localparam logic [9*WD-1:0] KH = {8'h01, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFE, 8'hFF};

    logic            clk = 1'b0;
    logic            rst;
    logic            sof;
    logic            x_valid_in;
    logic            x_ready_in;
    logic            x_valid_out;
    logic            x_ready_out;
    logic [9*WD-1:0] kernel_flat;
    logic            kernel_sel;
    logic            det_valid;
    logic            det_crossing;
    logic [7:0]      det_stripes;
    logic            crossing_confirmed;
    logic [7:0]      last_stripes;
    logic            frame_done;
    logic            timeout_flag;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;

    frame_kernel_scheduler #(
        .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(WD),
        .HIST_LEN(8), .VOTE_THRESH(5), .DRAIN_TIMEOUT(T)
    ) dut (
        .clk(clk), .rst(rst), .sof(sof),
        .x_valid_in(x_valid_in), .x_ready_in(x_ready_in),
        .x_valid_out(x_valid_out), .x_ready_out(x_ready_out),
        .kernel_flat(kernel_flat), .kernel_sel(kernel_sel),
        .det_valid(det_valid), .det_crossing(det_crossing), .det_stripes(det_stripes),
        .crossing_confirmed(crossing_confirmed), .last_stripes(last_stripes),
        .frame_done(frame_done), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (x_valid_out && x_ready_out) xfer_cnt++;
        if (frame_done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sof = 1'b0; x_valid_in = 1'b0; x_ready_out = 1'b0;
        det_valid = 1'b0; det_crossing = 1'b0; det_stripes = '0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic drive_frame();
        sof = 1'b1; x_valid_in = 1'b1; x_ready_out = 1'b1;
        for (int i = 0; i < PIX; i++) begin
            step();
            sof = 1'b0;
        end
        x_valid_in = 1'b0;
    endtask

    task automatic finish_frame(input logic c, input logic [7:0] s);
        det_valid = 1'b1; det_crossing = c; det_stripes = s;
        step();
        det_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; sof = 1'b1; x_valid_in = 1'b1; x_ready_out = 1'b1;
        det_valid = 1'b1; det_crossing = 1'b1; det_stripes = 8'hA5;
        step(); step();
        checks++; if (x_ready_in !== 1'b0) begin errors++; $display("FAIL rst_x_ready_in got %0b exp 0", x_ready_in); end
        checks++; if (x_valid_out !== 1'b0) begin errors++; $display("FAIL rst_x_valid_out got %0b exp 0", x_valid_out); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %0b exp 0", frame_done); end
        checks++; if (crossing_confirmed !== 1'b0) begin errors++; $display("FAIL rst_confirmed got %0b exp 0", crossing_confirmed); end
        checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0b exp 0", timeout_flag); end
        checks++; if (last_stripes !== 8'h00) begin errors++; $display("FAIL rst_last_stripes got %h exp 00", last_stripes); end
        checks++; if (kernel_sel !== 1'b0) begin errors++; $display("FAIL rst_kernel_sel got %0b exp 0", kernel_sel); end
        checks++; if (kernel_flat !== KV) begin errors++; $display("FAIL rst_kernel_flat got %h exp %h", kernel_flat, KV); end
        rst = 1'b0; sof = 1'b0; x_valid_in = 1'b0; det_valid = 1'b0;
        #1;
        checks++; if (x_ready_in !== 1'b1) begin errors++; $display("FAIL idle_x_ready_in got %0b exp 1", x_ready_in); end
        step();
    endtask

    task automatic test_pre_sof();
        int base;
        do_reset();
        base = xfer_cnt;
        sof = 1'b0; x_valid_in = 1'b1; x_ready_out = 1'b1;
        #1;
        checks++; if (x_ready_in !== 1'b1) begin errors++; $display("FAIL pre_sof_ready got %0b exp 1", x_ready_in); end
        checks++; if (x_valid_out !== 1'b0) begin errors++; $display("FAIL pre_sof_valid_out got %0b exp 0", x_valid_out); end
        repeat (5) step();
        checks++; if (xfer_cnt - base !== 0) begin errors++; $display("FAIL pre_sof_count got %0d exp 0", xfer_cnt - base); end
        checks++; if (x_ready_in !== 1'b1) begin errors++; $display("FAIL pre_sof_still_idle got %0b exp 1", x_ready_in); end
        x_valid_in = 1'b0;
    endtask

    task automatic test_basic_frame();
        int base;
        int dbase;
        do_reset();
        base = xfer_cnt;
        dbase = done_cnt;
        drive_frame();
        x_valid_in = 1'b1;
        #1;
        checks++; if (x_ready_in !== 1'b0) begin errors++; $display("FAIL drain_ready got %0b exp 0", x_ready_in); end
        checks++; if (x_valid_out !== 1'b0) begin errors++; $display("FAIL drain_valid_out got %0b exp 0", x_valid_out); end
        checks++; if (xfer_cnt - base !== PIX) begin errors++; $display("FAIL frame_pixels got %0d exp %0d", xfer_cnt - base, PIX); end
        step(); step();
        det_valid = 1'b1; det_crossing = 1'b1; det_stripes = 8'h2A;
        step();
        det_valid = 1'b0;
        checks++; if (last_stripes !== 8'h2A) begin errors++; $display("FAIL stripes_latch got %h exp 2a", last_stripes); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL done_early got %0b exp 0", frame_done); end
        checks++; if (x_ready_in !== 1'b0) begin errors++; $display("FAIL vote_ready got %0b exp 0", x_ready_in); end
        step();
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL done_pulse got %0b exp 1", frame_done); end
        checks++; if (kernel_sel !== 1'b1) begin errors++; $display("FAIL ksel_toggle got %0b exp 1", kernel_sel); end
        checks++; if (kernel_flat !== KH) begin errors++; $display("FAIL kflat_horiz got %h exp %h", kernel_flat, KH); end
        checks++; if (x_ready_in !== 1'b1) begin errors++; $display("FAIL back_idle_ready got %0b exp 1", x_ready_in); end
        checks++; if (crossing_confirmed !== 1'b0) begin errors++; $display("FAIL one_vote got %0b exp 0", crossing_confirmed); end
        x_valid_in = 1'b0;
        step();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL done_width got %0b exp 0", frame_done); end
        checks++; if (done_cnt - dbase !== 1) begin errors++; $display("FAIL done_count got %0d exp 1", done_cnt - dbase); end
    endtask

    task automatic test_vote();
        bit exp_cc [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        bit exp_ks [9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
        do_reset();
        for (int f = 0; f < 9; f++) begin
            drive_frame();
            finish_frame((f < 5) ? 1'b1 : 1'b0, 8'(f));
            checks++; if (crossing_confirmed !== exp_cc[f]) begin errors++; $display("FAIL vote_f%0d got %0b exp %0b", f + 1, crossing_confirmed, exp_cc[f]); end
            checks++; if (kernel_sel !== exp_ks[f]) begin errors++; $display("FAIL vote_ksel_f%0d got %0b exp %0b", f + 1, kernel_sel, exp_ks[f]); end
        end
    endtask

    task automatic test_timeout();
        int found;
        do_reset();
        drive_frame();
        found = 0;
        for (int cnt = 1; cnt <= T + 6; cnt++) begin
            step();
            if (cnt == T) begin
                checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL timeout_early got %0b exp 0", timeout_flag); end
            end
            if (cnt == T + 1) begin
                checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL timeout_set got %0b exp 1", timeout_flag); end
            end
            if (frame_done === 1'b1 && found == 0) found = cnt;
        end
        checks++; if (found !== T + 2) begin errors++; $display("FAIL timeout_done_cycle got %0d exp %0d", found, T + 2); end
        checks++; if (crossing_confirmed !== 1'b0) begin errors++; $display("FAIL timeout_vote got %0b exp 0", crossing_confirmed); end
        checks++; if (last_stripes !== 8'h00) begin errors++; $display("FAIL timeout_stripes got %h exp 00", last_stripes); end
        drive_frame();
        finish_frame(1'b1, 8'h11);
        checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %0b exp 1", timeout_flag); end
        checks++; if (last_stripes !== 8'h11) begin errors++; $display("FAIL good_after_timeout got %h exp 11", last_stripes); end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL good_after_done got %0b exp 1", frame_done); end
    endtask

    task automatic test_ignore();
        int base;
        do_reset();
        base = xfer_cnt;
        x_ready_out = 1'b1; x_valid_in = 1'b1; det_crossing = 1'b1;
        for (int i = 0; i < PIX; i++) begin
            sof = (i == 0 || i == 5);
            det_valid = (i == 5 || i == PIX - 1);
            det_stripes = (i == PIX - 1) ? 8'h77 : 8'h55;
            if (i == 3) begin
                x_ready_out = 1'b0;
                #1;
                checks++; if (x_ready_in !== 1'b0) begin errors++; $display("FAIL stall_pass got %0b exp 0", x_ready_in); end
                checks++; if (x_valid_out !== 1'b1) begin errors++; $display("FAIL stall_valid got %0b exp 1", x_valid_out); end
                step(); step();
                x_ready_out = 1'b1;
            end
            if (i == PIX - 1) begin
                #1;
                checks++; if (x_ready_in !== 1'b1) begin errors++; $display("FAIL last_pix_ready got %0b exp 1", x_ready_in); end
            end
            step();
        end
        sof = 1'b0; det_valid = 1'b0; x_valid_in = 1'b0;
        checks++; if (xfer_cnt - base !== PIX) begin errors++; $display("FAIL ignore_count got %0d exp %0d", xfer_cnt - base, PIX); end
        checks++; if (x_ready_in !== 1'b0) begin errors++; $display("FAIL ignore_drain got %0b exp 0", x_ready_in); end
        checks++; if (last_stripes !== 8'h00) begin errors++; $display("FAIL ignore_stripes got %h exp 00", last_stripes); end
        step();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL ignore_no_done got %0b exp 0", frame_done); end
        checks++; if (x_ready_in !== 1'b0) begin errors++; $display("FAIL ignore_still_drain got %0b exp 0", x_ready_in); end
        finish_frame(1'b0, 8'h33);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL ignore_done got %0b exp 1", frame_done); end
        checks++; if (last_stripes !== 8'h33) begin errors++; $display("FAIL ignore_latch got %h exp 33", last_stripes); end
        checks++; if (crossing_confirmed !== 1'b0) begin errors++; $display("FAIL ignore_vote got %0b exp 0", crossing_confirmed); end
    endtask

    task automatic test_mid_reset();
        int base;
        do_reset();
        for (int f = 0; f < 5; f++) begin
            drive_frame();
            finish_frame(1'b1, 8'h44);
        end
        checks++; if (crossing_confirmed !== 1'b1) begin errors++; $display("FAIL pre_rst_vote got %0b exp 1", crossing_confirmed); end
        sof = 1'b1; x_valid_in = 1'b1; x_ready_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            sof = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (x_ready_in !== 1'b0) begin errors++; $display("FAIL async_ready got %0b exp 0", x_ready_in); end
        checks++; if (x_valid_out !== 1'b0) begin errors++; $display("FAIL async_valid got %0b exp 0", x_valid_out); end
        checks++; if (crossing_confirmed !== 1'b0) begin errors++; $display("FAIL async_vote got %0b exp 0", crossing_confirmed); end
        checks++; if (kernel_sel !== 1'b0) begin errors++; $display("FAIL async_ksel got %0b exp 0", kernel_sel); end
        checks++; if (kernel_flat !== KV) begin errors++; $display("FAIL async_kflat got %h exp %h", kernel_flat, KV); end
        checks++; if (last_stripes !== 8'h00) begin errors++; $display("FAIL async_stripes got %h exp 00", last_stripes); end
        step();
        rst = 1'b0;
        base = xfer_cnt;
        repeat (3) step();
        checks++; if (xfer_cnt - base !== 0) begin errors++; $display("FAIL rst_needs_sof got %0d exp 0", xfer_cnt - base); end
        drive_frame();
        checks++; if (xfer_cnt - base !== PIX) begin errors++; $display("FAIL recover_count got %0d exp %0d", xfer_cnt - base, PIX); end
        checks++; if (x_ready_in !== 1'b0) begin errors++; $display("FAIL recover_drain got %0b exp 0", x_ready_in); end
        finish_frame(1'b1, 8'h66);
        checks++; if (crossing_confirmed !== 1'b0) begin errors++; $display("FAIL hist_cleared got %0b exp 0", crossing_confirmed); end
        checks++; if (kernel_sel !== 1'b1) begin errors++; $display("FAIL recover_ksel got %0b exp 1", kernel_sel); end
    endtask

    initial begin
        test_reset();
        test_pre_sof();
        test_basic_frame();
        test_vote();
        test_timeout();
        test_ignore();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
